bank_arbiter: RTL

Arbitrates one synchronous single-port memory bank (1R/1W, one-cycle read, write-first) among `NUM_REQ` requesters, for example a weight loader, an activation streamer and the host DMA.
- Round-robin arbitration between requesters.
- Optional burst locking: a requester holds the bank until it marks a beat as last.
- Drives the bank's `we/addr/din` and steers `dout` back to the requester that issued the read.

Sits between the tile-level clients and one `MemoryBank` instance.

---
 rtl/bank_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bank_arbiter.sv
// Round-robin arbiter with burst locking in front of one 1R/1W write-first memory bank.
// Optional: define BANK_ARB_RSP_REG_EN to register the read response (read latency 2 instead of 1).
module bank_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int BURST_MAX = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_din,
  input  logic [DATA_W-1:0]         mem_dout
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_MAX) + 1;

  typedef enum logic {S_IDLE, S_LOCK} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      own_q, own_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] rd_pend_q, rd_pend_d;
  logic [PW-1:0]      gnt_idx, scan_idx;
  logic               gnt_vld, acc;

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    if (state_q == S_LOCK) begin
      gnt_vld = req_valid[own_q];
      gnt_idx = own_q;
    end else begin
      // Scan from lowest to highest priority so the slot right after ptr is written last.
      for (int k = NUM_REQ; k >= 1; k--) begin
        scan_idx = PW'((int'(ptr_q) + k) % NUM_REQ);
        if (req_valid[scan_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
  end

  assign acc = gnt_vld & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= PW'(NUM_REQ - 1);
      own_q     <= '0;
      cnt_q     <= '0;
      rd_pend_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    if (acc) begin
      case (state_q)
        S_IDLE: begin
          if (req_last[gnt_idx] || BURST_MAX == 1) begin
            ptr_d = gnt_idx;
          end else begin
            state_d = S_LOCK;
            own_d   = gnt_idx;
            cnt_d   = CW'(1);
          end
        end
        default: begin
          // The beat-count release fires even without req_last.
          if (req_last[own_q] || (cnt_q + CW'(1)) == CW'(BURST_MAX)) begin
            state_d = S_IDLE;
            ptr_d   = own_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    rd_pend_d = '0;
    if (acc) begin
      req_ready[gnt_idx] = 1'b1;
      mem_we             = req_we[gnt_idx];
      mem_addr           = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      mem_din            = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
      if (!req_we[gnt_idx]) rd_pend_d[gnt_idx] = 1'b1;
    end
  end

`ifdef BANK_ARB_RSP_REG_EN
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rd_pend_q;
      rsp_rdata_q <= (|rd_pend_q) ? mem_dout : '0;
    end
  end

  assign rsp_valid = rst ? '0 : rsp_valid_q;
  assign rsp_rdata = rst ? '0 : rsp_rdata_q;
`else
  assign rsp_valid = rst ? '0 : rd_pend_q;
  assign rsp_rdata = (rst || rd_pend_q == '0) ? '0 : mem_dout;
`endif

endmodule
